// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
// Shared ALUOp codes, R-type funct constants and the R-type encode helper.
// The control decoder imports the same package, which keeps both sides of
// the ALUOp encoding in one place.
package instr_encoder_pkg;

   typedef enum logic [3:0] {
      OP_JR   = 4'b0000,
      OP_ADD  = 4'b0001,
      OP_SUB  = 4'b0010,
      OP_AND  = 4'b0011,
      OP_OR   = 4'b0100,
      OP_NOR  = 4'b0101,
      OP_SLT  = 4'b0110,
      OP_SLL  = 4'b0111,
      OP_SRL  = 4'b1000,
      OP_SRA  = 4'b1001,
      OP_ADDU = 4'b1010,
      OP_SUBU = 4'b1011
   } aluop_e;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_JR   = 6'b001000;

   // Raw request; op is kept as plain bits so unmapped codes can be carried.
   typedef struct packed {
      logic [3:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
   } enc_req_t;

   typedef struct packed {
      logic        ok;    // op code was recognised
      logic [31:0] word;
   } enc_rsp_t;

   // Build the R-type word, zeroing the fields each op does not use.
   function automatic enc_rsp_t encode(input enc_req_t r);
      enc_rsp_t   rsp;
      logic [4:0] rs, rt, rd, sh;
      logic [5:0] fn;
      rsp.ok = 1'b1;
      rs     = r.rs;
      rt     = r.rt;
      rd     = r.rd;
      sh     = 5'd0;
      fn     = 6'd0;
      case (r.op)
         OP_ADD:  fn = FN_ADD;
         OP_ADDU: fn = FN_ADDU;
         OP_SUB:  fn = FN_SUB;
         OP_SUBU: fn = FN_SUBU;
         OP_AND:  fn = FN_AND;
         OP_OR:   fn = FN_OR;
         OP_NOR:  fn = FN_NOR;
         OP_SLT:  fn = FN_SLT;
         OP_SLL:  begin fn = FN_SLL; rs = 5'd0; sh = r.shamt; end
         OP_SRL:  begin fn = FN_SRL; rs = 5'd0; sh = r.shamt; end
         OP_SRA:  begin fn = FN_SRA; rs = 5'd0; sh = r.shamt; end
         OP_JR:   begin fn = FN_JR;  rt = 5'd0; rd = 5'd0; end
         default: rsp.ok = 1'b0;
      endcase
      rsp.word = {6'b000000, rs, rt, rd, sh, fn};
      return rsp;
   endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo
// Synchronous FIFO holding encoded words between acceptance and the
// instruction-memory write port.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears occupancy)
//   push, wdata     write side; ignored when full
//   pop, rdata      read side; rdata is the current head, pop ignored when empty
//   full, empty     status
//   count           occupancy, 0..DEPTH
module enc_fifo
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // DEPTH is a power of two, so the pointers wrap by overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Encodes ALUOp requests into R-type instruction words, queues them, and
// drains them into instruction memory at a self-incrementing address.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               request handshake (in_ready = not full)
//   in_op, in_rs, in_rt, in_rd,
//   in_shamt                        request fields
//   addr_load, start_addr           reload write pointer (wins over drain)
//   imem_stall                      hold off drain
//   imem_we, imem_addr, imem_wdata  registered instruction-memory write port
//   fifo_count                      queue occupancy
//   bad_op                          sticky unmapped-op flag, cleared by addr_load
//   wrapped                         high alongside the write to address all-ones
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_op,
   input  logic [4:0]             in_rs,
   input  logic [4:0]             in_rt,
   input  logic [4:0]             in_rd,
   input  logic [4:0]             in_shamt,
   input  logic                   addr_load,
   input  logic [ADDR_W-1:0]      start_addr,
   input  logic                   imem_stall,
   output logic                   imem_we,
   output logic [ADDR_W-1:0]      imem_addr,
   output logic [31:0]            imem_wdata,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   bad_op,
   output logic                   wrapped
);

   enc_req_t          req;
   enc_rsp_t          rsp;
   logic              full, empty;
   logic [31:0]       head;
   logic              accept, push, drain;
   logic [ADDR_W-1:0] ptr;

   assign req      = {in_op, in_rs, in_rt, in_rd, in_shamt};
   assign rsp      = encode(req);
   assign in_ready = ~full;
   assign accept   = in_valid & in_ready;
   // Unmapped ops complete the handshake but never reach the queue.
   assign push     = accept & rsp.ok;
   assign drain    = ~empty & ~imem_stall & ~addr_load;

   enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (rsp.word),
      .pop   (drain),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         bad_op     <= 1'b0;
         wrapped    <= 1'b0;
      end else if (addr_load) begin
         // Reload stalls the write port for a cycle; queued words stay put.
         ptr     <= start_addr;
         imem_we <= 1'b0;
         wrapped <= 1'b0;
         bad_op  <= 1'b0;
      end else begin
         imem_we <= drain;
         wrapped <= drain & (&ptr);
         if (drain) begin
            imem_addr  <= ptr;
            imem_wdata <= head;
            ptr        <= ptr + ADDR_W'(1);
         end
         if (accept && !rsp.ok) bad_op <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Directed bench with a scoreboard: each accepted, mapped request pushes its
// expected {addr, word, wrapped}; a negedge monitor pops on every write.
module tb_instr_encoder;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
   logic              addr_load;
   logic [ADDR_W-1:0] start_addr;
   logic              imem_stall;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [$clog2(DEPTH):0] fifo_count;
   logic              bad_op;
   logic              wrapped;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic        wr;
   } exp_t;

   exp_t       sbq[$];
   int         tests;
   int         fails;
   logic [7:0] model_ptr;
   logic [3:0] ops [12] = '{4'b0001, 4'b1010, 4'b0010, 4'b1011, 4'b0011, 4'b0100,
                            4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0000};

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rd      (in_rd),
      .in_shamt   (in_shamt),
      .addr_load  (addr_load),
      .start_addr (start_addr),
      .imem_stall (imem_stall),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .fifo_count (fifo_count),
      .bad_op     (bad_op),
      .wrapped    (wrapped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference encoder: {ok, word}
   function automatic logic [32:0] model(input logic [3:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
      logic [5:0] f;
      logic       ok;
      logic [4:0] a, b, c, d;
      ok = 1'b1; a = rs; b = rt; c = rd; d = 5'd0; f = 6'd0;
      case (op)
         4'b0001: f = 6'b100000;
         4'b1010: f = 6'b100001;
         4'b0010: f = 6'b100010;
         4'b1011: f = 6'b100011;
         4'b0011: f = 6'b100100;
         4'b0100: f = 6'b100101;
         4'b0101: f = 6'b100111;
         4'b0110: f = 6'b101010;
         4'b0111: begin f = 6'b000000; a = 5'd0; d = sh; end
         4'b1000: begin f = 6'b000010; a = 5'd0; d = sh; end
         4'b1001: begin f = 6'b000011; a = 5'd0; d = sh; end
         4'b0000: begin f = 6'b001000; b = 5'd0; c = 5'd0; end
         default: ok = 1'b0;
      endcase
      return {ok, 6'b000000, a, b, c, d, f};
   endfunction

   task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh);
      logic [32:0] m;
      exp_t        e;
      int          n;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         chk("ready_timeout", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      m = model(op, rs, rt, rd, sh);
      if (m[32]) begin
         e.addr = model_ptr;
         e.data = m[31:0];
         e.wr   = (model_ptr == 8'hFF);
         sbq.push_back(e);
         model_ptr = model_ptr + 8'd1;
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] a);
      @(negedge clk);
      addr_load = 1'b1; start_addr = a;
      @(posedge clk);
      #1 addr_load = 1'b0;
      model_ptr = a;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((fifo_count != 0 || sbq.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("drain_idle", 32'(sbq.size()), 32'd0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (imem_we === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("write_expected", 32'(sbq.size()), 32'd1);
         end else begin
            e = sbq.pop_front();
            chk("wr_addr", {24'd0, imem_addr}, {24'd0, e.addr});
            chk("wr_data", imem_wdata, e.data);
            chk("wr_wrap", {31'd0, wrapped}, {31'd0, e.wr});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0; model_ptr = 8'd0;
      rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0;
      in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
      addr_load = 1'b0; start_addr = 8'd0; imem_stall = 1'b0;
      #12;
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_we",    {31'd0, imem_we}, 32'd0);
      chk("rst_addr",  {24'd0, imem_addr}, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_bad",   {31'd0, bad_op}, 32'd0);
      chk("rst_wrap",  {31'd0, wrapped}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // ADD example with one-cycle latency
      do_load(8'h10);
      send(4'b0001, 5'd1, 5'd2, 5'd3, 5'd0);
      @(posedge clk); #1;
      chk("lat_we",   {31'd0, imem_we}, 32'd1);
      chk("lat_addr", {24'd0, imem_addr}, 32'h10);
      chk("lat_data", imem_wdata, 32'h00221820);

      // SLL / JR forcing, then every op with random fields
      send(4'b0111, 5'd7, 5'd5, 5'd4, 5'd2);
      send(4'b0000, 5'd31, 5'd9, 5'd9, 5'd9);
      for (int i = 0; i < 12; i++)
         send(ops[i], 5'($urandom_range(31)), 5'($urandom_range(31)),
              5'($urandom_range(31)), 5'($urandom_range(31)));
      wait_idle();

      // simultaneous push and pop keeps the count
      imem_stall = 1'b1;
      send(4'b0011, 5'd1, 5'd1, 5'd1, 5'd1);
      send(4'b0100, 5'd2, 5'd2, 5'd2, 5'd2);
      chk("pp_count_pre", 32'(fifo_count), 32'd2);
      fork
         send(4'b0101, 5'd3, 5'd3, 5'd3, 5'd3);
         begin
            @(negedge clk) imem_stall = 1'b0;
            @(posedge clk); #1;
            chk("pp_count", 32'(fifo_count), 32'd2);
         end
      join
      wait_idle();

      // fill under stall, 5th request waits, then consecutive drain
      imem_stall = 1'b1;
      for (int i = 0; i < 4; i++) send(4'b0001, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0);
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      chk("full_count", 32'(fifo_count), 32'd4);
      fork
         send(4'b0010, 5'd3, 5'd4, 5'd5, 5'd0);
         begin
            repeat (3) @(negedge clk);
            chk("held_count", 32'(fifo_count), 32'd4);
            imem_stall = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("consec_we", {31'd0, imem_we}, 32'd1);
            end
         end
      join
      wait_idle();

      // pointer wrap
      do_load(8'hFF);
      send(4'b0110, 5'd4, 5'd5, 5'd6, 5'd0);
      send(4'b1000, 5'd4, 5'd5, 5'd6, 5'd7);
      wait_idle();

      // unmapped op
      send(4'b1100, 5'd1, 5'd2, 5'd3, 5'd4);
      repeat (3) @(negedge clk);
      chk("bad_set",   {31'd0, bad_op}, 32'd1);
      chk("bad_count", 32'(fifo_count), 32'd0);
      do_load(8'h20);
      chk("bad_clr",   {31'd0, bad_op}, 32'd0);

      // addr_load beats drain, contents retained
      imem_stall = 1'b1;
      model_ptr = 8'h40;
      send(4'b1001, 5'd1, 5'd2, 5'd3, 5'd4);
      send(4'b1011, 5'd5, 5'd6, 5'd7, 5'd8);
      @(negedge clk);
      imem_stall = 1'b0; addr_load = 1'b1; start_addr = 8'h40;
      @(posedge clk); #1;
      chk("prio_we",    {31'd0, imem_we}, 32'd0);
      chk("prio_count", 32'(fifo_count), 32'd2);
      addr_load = 1'b0;
      wait_idle();

      // reset mid-drain discards queue
      imem_stall = 1'b1;
      send(4'b0001, 5'd1, 5'd1, 5'd1, 5'd0);
      send(4'b0001, 5'd2, 5'd2, 5'd2, 5'd0);
      send(4'b0001, 5'd3, 5'd3, 5'd3, 5'd0);
      chk("q3_count", 32'(fifo_count), 32'd3);
      @(negedge clk) imem_stall = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_we",    {31'd0, imem_we}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      sbq.delete();
      model_ptr = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_count", 32'(fifo_count), 32'd0);
      send(4'b0101, 5'd9, 5'd10, 5'd11, 5'd0);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
